// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one 8-bit ALU; round-robin priority with per-op
// ownership lock and a single registered result slot with valid/ready drain.

module alu (
   input  logic [2:0] op,
   input  logic [7:0] reg_val,
   input  logic [7:0] acc_val,
   output logic [7:0] result
);
   always_comb begin
      result = '0;
      unique case (op)
         3'd0: result = reg_val + acc_val;
         3'd1: result = reg_val - acc_val;
         3'd2: result = (reg_val >= 8'd8) ? '0 : acc_val << reg_val[2:0];
         3'd3: result = (reg_val >= 8'd8) ? '0 : acc_val >> reg_val[2:0];
         3'd4: result = {7'd0, acc_val == reg_val};
         3'd5: result = {7'd0, reg_val > acc_val};
         3'd6: result = reg_val & acc_val;
         3'd7: result = reg_val ^ acc_val;
         default: result = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int unsigned FIRST_PRI = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [2:0] req0_op,
   input  logic [7:0] req0_reg,
   input  logic [7:0] req0_acc,
   input  logic       req0_lock,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_op,
   input  logic [7:0] req1_reg,
   input  logic [7:0] req1_acc,
   input  logic       req1_lock,
   output logic       req1_ready,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   input  logic       rsp_ready
);
   typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

   localparam logic PRI_RST = (FIRST_PRI != 0);

   state_t     state, state_nxt;
   logic       pri;
   logic       can_accept;
   logic       sel;
   logic       elig;
   logic       accept;
   logic       sel_lock;
   logic [2:0] alu_op;
   logic [7:0] alu_reg;
   logic [7:0] alu_acc;
   logic [7:0] alu_res;

   assign can_accept = !rsp_valid || rsp_ready;

   // sel names the candidate requester; elig says whether it may be granted
   always_comb begin
      sel  = pri;
      elig = 1'b0;
      unique case (state)
         FREE: begin
            if (req0_valid && req1_valid) begin
               sel  = pri;
               elig = 1'b1;
            end else if (req0_valid) begin
               sel  = 1'b0;
               elig = 1'b1;
            end else if (req1_valid) begin
               sel  = 1'b1;
               elig = 1'b1;
            end
         end
         OWN0: begin
            sel  = 1'b0;
            elig = req0_valid;
         end
         OWN1: begin
            sel  = 1'b1;
            elig = req1_valid;
         end
         default: begin
            sel  = pri;
            elig = 1'b0;
         end
      endcase

      accept     = !reset && can_accept && elig;
      req0_ready = accept && !sel;
      req1_ready = accept && sel;

      sel_lock = sel ? req1_lock : req0_lock;
      alu_op   = sel ? req1_op  : req0_op;
      alu_reg  = sel ? req1_reg : req0_reg;
      alu_acc  = sel ? req1_acc : req0_acc;

      state_nxt = state;
      if (accept)
         state_nxt = sel_lock ? (sel ? OWN1 : OWN0) : FREE;
   end

   alu u_alu (
      .op      (alu_op),
      .reg_val (alu_reg),
      .acc_val (alu_acc),
      .result  (alu_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FREE;
         pri       <= PRI_RST;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= sel;
            rsp_data  <= alu_res;
            pri       <= ~sel;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule
